// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-index width, the zero register and the
// hazard sequencer state encoding.
package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  typedef enum logic [1:0] {
    HS_RUN      = ST_RUN,
    HS_MEM_WAIT = ST_MEM_WAIT,
    HS_FAULT    = ST_FAULT
  } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID instruction reads a register that
// the load currently in EX has not yet written.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             load_use
);

  // A load targeting the zero register never produces a real dependency.
  assign load_use = ex_mem_read && (ex_rt != ZERO_REG) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/hazard_sequencer.sv
// Central pipeline controller: stall, squash and memory-wait sequencing with a
// sticky timeout fault and a saturating stall-cycle counter.
module hazard_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_keep,
  output logic             if_id_flush,
  output logic             id_ex_keep,
  output logic             id_ex_flush,
  output logic             ex_mem_keep,
  output logic             mem_wb_flush,
  output logic             fault,
  output logic [1:0]       hazard_state,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [15:0]      WAIT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  hazard_state_t state;
  logic [15:0]   wait_cnt;
  logic          load_use;
  logic          mem_stall;
  logic          freeze;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  assign mem_stall    = mem_req && !mem_ready;
  assign freeze       = (state == HS_FAULT) || mem_stall;
  assign hazard_state = state;

  // Priority: freeze, taken branch, load-use bubble, jump squash, run.
  always_comb begin
    pc_write     = 1'b0;
    if_id_keep   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_keep   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_keep  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      if (freeze) begin
        if_id_keep   = 1'b1;
        id_ex_keep   = 1'b1;
        ex_mem_keep  = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        pc_write    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        if_id_keep  = 1'b1;
        id_ex_flush = 1'b1;
      end else if (id_jump) begin
        pc_write    = 1'b1;
        if_id_flush = 1'b1;
      end else begin
        pc_write = 1'b1;
      end
    end
  end

  // A dropped mem_req while waiting returns to RUN without faulting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HS_RUN;
      wait_cnt <= 16'd0;
      fault    <= 1'b0;
    end else begin
      case (state)
        HS_RUN: begin
          if (mem_stall) begin
            state    <= HS_MEM_WAIT;
            wait_cnt <= 16'd1;
          end
        end
        HS_MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= HS_RUN;
            wait_cnt <= 16'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= HS_FAULT;
            fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        HS_FAULT: begin
          state <= HS_FAULT;
          fault <= 1'b1;
        end
        default: begin
          state    <= HS_RUN;
          wait_cnt <= 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized self-checking bench for hazard_sequencer against a cycle-level
// behavioural model of the stall/squash rules and memory-wait timeout.
module tb_hazard_sequencer;

  localparam int TIMEOUT   = 4;
  localparam int CW        = 3;
  localparam int STALL_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rs, id_uses_rt, id_jump;
  logic          ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_write, if_id_keep, if_id_flush, id_ex_keep, id_ex_flush;
  logic          ex_mem_keep, mem_wb_flush, fault;
  logic [1:0]    hazard_state;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  bit mFault;
  int mWait;
  int mStall;

  hazard_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_keep      (if_id_keep),
    .if_id_flush     (if_id_flush),
    .id_ex_keep      (id_ex_keep),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_keep     (ex_mem_keep),
    .mem_wb_flush    (mem_wb_flush),
    .fault           (fault),
    .hazard_state    (hazard_state),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected controls packed as {pc_write, if_id_keep, if_id_flush, id_ex_keep, id_ex_flush, ex_mem_keep, mem_wb_flush}.
  function automatic logic [6:0] expCtrl();
    logic lu;
    lu = ex_mem_read && (ex_rt != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    if (reset) return 7'b0000000;
    if (mFault || (mem_req && !mem_ready)) return 7'b0101011;
    if (ex_branch_taken) return 7'b1010100;
    if (lu) return 7'b0100100;
    if (id_jump) return 7'b1010000;
    return 7'b1000000;
  endfunction

  function automatic logic [6:0] dutCtrl();
    return {pc_write, if_id_keep, if_id_flush, id_ex_keep, id_ex_flush, ex_mem_keep, mem_wb_flush};
  endfunction

  task automatic clearInputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Called just after a negedge with inputs set; checks, advances the model, returns at the next negedge.
  task automatic applyStimulus(input string tag);
    logic [6:0] e;
    #1;
    e = expCtrl();
    checkOutput({tag, "_ctrl"}, 32'(dutCtrl()), 32'(e));
    checkOutput({tag, "_state"}, 32'(hazard_state), mFault ? 32'd2 : (mWait > 0 ? 32'd1 : 32'd0));
    checkOutput({tag, "_fault"}, 32'(fault), 32'(mFault));
    checkOutput({tag, "_stall"}, 32'(stall_count), 32'(mStall));
    if (!e[6] && mStall < STALL_MAX) mStall++;
    if (!mFault) begin
      if (mem_req && !mem_ready) begin
        mWait++;
        if (mWait >= TIMEOUT) mFault = 1'b1;
      end else begin
        mWait = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    #1;
    checkOutput({tag, "_ctrl"}, 32'(dutCtrl()), 32'd0);
    checkOutput({tag, "_state"}, 32'(hazard_state), 32'd0);
    checkOutput({tag, "_fault"}, 32'(fault), 32'd0);
    checkOutput({tag, "_stall"}, 32'(stall_count), 32'd0);
    mFault = 1'b0; mWait = 0; mStall = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    mFault = 1'b0; mWait = 0; mStall = 0;
    @(negedge clk);
    doReset("reset");

    clearInputs();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    applyStimulus("loaduse");
    checkOutput("loaduse_cnt", 32'(stall_count), 32'd1);
    ex_rt = 5'd0; id_rs = 5'd0;
    applyStimulus("loaduse_r0");
    checkOutput("loaduse_r0_cnt", 32'(stall_count), 32'd1);

    clearInputs();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    id_jump = 1'b1; ex_branch_taken = 1'b1;
    applyStimulus("branch_over");

    clearInputs();
    mem_req = 1'b1;
    repeat (3) applyStimulus("memwait");
    mem_ready = 1'b1; id_jump = 1'b1;
    applyStimulus("memwait_release");
    checkOutput("memwait_cnt", 32'(stall_count), 32'd4);

    doReset("reset2");
    clearInputs();
    mem_req = 1'b1;
    repeat (4) applyStimulus("timeout");
    checkOutput("timeout_state", 32'(hazard_state), 32'd2);
    checkOutput("timeout_fault", 32'(fault), 32'd1);
    mem_ready = 1'b1;
    applyStimulus("fault_hold");
    doReset("fault_reset");

    clearInputs();
    mem_req = 1'b1; mem_ready = 1'b1; id_jump = 1'b1;
    applyStimulus("zero_wait_jump");

    clearInputs();
    ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    repeat (10) applyStimulus("saturate");
    checkOutput("saturate_cnt", 32'(stall_count), 32'd7);

    clearInputs();
    mem_req = 1'b1;
    repeat (2) applyStimulus("midwait");
    doReset("midwait_reset");

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0 || (mFault && $urandom_range(0, 3) == 0)) begin
        doReset("rand_reset");
      end
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_jump         = ($urandom_range(0, 3) == 0);
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_req         = (mWait > 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, 2) == 0);
      applyStimulus("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central pipeline controller for the 5-stage CPU. It drives the PC write-enable and the keep/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves four events: load-use stalls, ID-stage jump squash, EX-stage taken-branch squash and variable-latency data-memory waits.
- A small FSM tracks memory waits and a timeout fault. A saturating counter records stall cycles for performance debug.

Parameters:
- MEM_TIMEOUT, 64, number of consecutive wait cycles in MEM_WAIT (without mem_ready) before entering FAULT; legal range 2..65535.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  ID instruction is j/jal/jr/jalr (target resolved in ID)
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  destination register of EX load
- ex_branch_taken  in  1  EX branch resolved taken
- mem_req  in  1  MEM instruction accesses data memory; held while waiting
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register update enable
- if_id_keep  out  1  hold IF/ID
- if_id_flush  out  1  clear IF/ID to bubble
- id_ex_keep  out  1  hold ID/EX
- id_ex_flush  out  1  clear ID/EX to bubble
- ex_mem_keep  out  1  hold EX/MEM
- mem_wb_flush  out  1  insert bubble into MEM/WB
- fault  out  1  sticky memory-timeout fault
- hazard_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 FAULT
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset (async): state=RUN, wait counter=0, stall_count=0, fault=0.
  - While reset is high, all outputs are 0 except hazard_state=0.
- Control outputs are combinational from the inputs and the registered state. State and counters update on posedge clk.
- Derived terms:
  - freeze = state==FAULT, or mem_req && !mem_ready (in RUN or MEM_WAIT).
  - load_use = ex_mem_read && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
- Priority, highest first:
  1. freeze: pc_write=0; if_id_keep, id_ex_keep, ex_mem_keep=1; mem_wb_flush=1; all other flushes 0.
  2. ex_branch_taken: pc_write=1; if_id_flush=1; id_ex_flush=1; keeps 0. This overrides load_use and id_jump because both ID-side events are squashed.
  3. load_use: pc_write=0; if_id_keep=1; id_ex_flush=1. One-cycle bubble; the jump is re-evaluated next cycle.
  4. id_jump: pc_write=1; if_id_flush=1.
  5. none: pc_write=1; all keep/flush 0.
- Invariant: a keep and a flush for the same register are never high together.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_req && !mem_ready; wait counter loads 1.
  - MEM_WAIT -> RUN when mem_ready; wait counter clears. The freeze releases in the same cycle mem_ready is high, and normal priority is evaluated in that cycle.
  - MEM_WAIT with !mem_ready: wait counter increments. When wait counter == MEM_TIMEOUT-1 and !mem_ready, next state is FAULT.
  - MEM_WAIT with mem_req dropped: return to RUN. This is a protocol violation; there is no fault.
  - FAULT: absorbing until reset. fault=1, freeze held, mem_ready ignored.
- mem_req && mem_ready in RUN: zero-wait access; stay in RUN; no freeze.
- stall_count: increments on every clock where pc_write=0 and reset is low. It saturates at 2^CNT_W-1 with no wrap, and counts FAULT cycles.
- Reset mid-wait: immediate return to RUN and all counters cleared.

Decomposition:
- Shared package (cpu_pkg):
  - hazard state encoding constants: ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_FAULT=2'd2;
  - register-index width 5;
  - constant ZERO_REG=5'd0.
- One sub-module, load_use_detect: purely combinational comparator producing load_use. It is reused by the forwarding unit review.
- FSM, wait counter and stall counter stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 for 1 cycle -> pc_write=0, if_id_keep=1, id_ex_flush=1; stall_count goes 0->1. Repeat with ex_rt=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 together with a load_use match and id_jump=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_keep=0.
- Memory wait of 3 cycles: mem_req=1, mem_ready=0 for 3 clocks then 1 -> freeze outputs for 3 cycles; hazard_state 0->1 (held 1,1) ->0; released in the mem_ready cycle; stall_count=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready never -> hazard_state=2 and fault=1 after 4 wait cycles. Freeze persists when mem_ready later rises; reset clears to RUN, fault=0.
- Zero-wait access plus jump: mem_req=1, mem_ready=1, id_jump=1 -> state stays RUN, pc_write=1, if_id_flush=1, no keeps.
- Saturation: CNT_W=3, hold load_use for 10 cycles -> stall_count sticks at 7. Async reset mid-MEM_WAIT -> all outputs 0 immediately, stall_count=0.
